// File: rtl/updown_counter_adv.sv
// Up/down timer counter with saw-up/saw-down/triangle modes, prescaler, one-shot and shadowed config.
// Latency: counter_o, counter_evt_o and counter_end_o update on the edge after the qualifying event.
// Backpressure: none; events arriving while inactive or done are dropped, config reloads wait for a period end.
module updown_counter_adv #(
    parameter int NUM_BITS   = 16,
    parameter int PRESC_BITS = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic                  cfg_oneshot_i,
    input  logic [NUM_BITS-1:0]   cfg_start_i,
    input  logic [NUM_BITS-1:0]   cfg_end_i,
    input  logic [PRESC_BITS-1:0] cfg_presc_i,
    input  logic                  ctrl_update_i,
    input  logic                  ctrl_rst_i,
    input  logic                  ctrl_active_i,
    input  logic                  counter_event_i,
    output logic [NUM_BITS-1:0]   counter_o,
    output logic                  counter_dir_o,
    output logic                  counter_evt_o,
    output logic                  counter_end_o,
    output logic                  counter_done_o
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_TRI  = 2'b10,
        MODE_RSV  = 2'b11
    } mode_e;

    // Shadow copies of the configuration; only these drive the counting logic.
    logic [NUM_BITS-1:0]   r_start;
    logic [NUM_BITS-1:0]   r_end;
    logic [PRESC_BITS-1:0] r_presc;
    mode_e                 r_mode;
    logic                  r_oneshot;

    logic [NUM_BITS-1:0]   cnt;
    logic                  dir;
    logic [PRESC_BITS-1:0] presc_cnt;
    logic                  pending;
    logic                  done;
    logic                  evt;
    logic                  end_pulse;

    logic                  qev;
    logic                  tick;
    logic [NUM_BITS-1:0]   adv_cnt;
    logic                  adv_dir;
    logic                  period_end;
    logic [NUM_BITS-1:0]   load_cnt;
    logic                  load_dir;
    logic                  tick_reload;
    logic                  reload;

    assign qev  = counter_event_i & ctrl_active_i & ~done;
    assign tick = qev & (presc_cnt == r_presc);

    // Next count/direction for a tick, and whether that tick closes a period.
    always_comb begin
        adv_cnt    = cnt;
        adv_dir    = dir;
        period_end = 1'b0;
        case (r_mode)
            MODE_DOWN: begin
                if (cnt == r_start) begin
                    adv_cnt    = r_end;
                    period_end = 1'b1;
                end else begin
                    adv_cnt = cnt - 1'b1;
                end
            end
            MODE_TRI: begin
                if (r_start == r_end) begin
                    period_end = 1'b1;
                end else if (!dir) begin
                    if (cnt == r_end) begin
                        adv_cnt = cnt - 1'b1;
                        adv_dir = 1'b1;
                    end else begin
                        adv_cnt = cnt + 1'b1;
                    end
                end else begin
                    if (cnt == r_start) begin
                        adv_cnt    = cnt + 1'b1;
                        adv_dir    = 1'b0;
                        period_end = 1'b1;
                    end else begin
                        adv_cnt = cnt - 1'b1;
                    end
                end
            end
            default: begin
                // Saw-up; the reserved encoding falls through here as well.
                if (cnt == r_end) begin
                    adv_cnt    = r_start;
                    period_end = 1'b1;
                end else begin
                    adv_cnt = cnt + 1'b1;
                end
            end
        endcase
    end

    // Reload value comes straight from cfg_* since the shadows are written on the same edge.
    always_comb begin
        load_cnt = cfg_start_i;
        load_dir = 1'b0;
        if (mode_e'(cfg_mode_i) == MODE_DOWN) begin
            load_cnt = cfg_end_i;
            load_dir = 1'b1;
        end
    end

    assign tick_reload = tick & period_end & (pending | ctrl_update_i);
    assign reload      = ctrl_rst_i
                       | (ctrl_update_i & (~ctrl_active_i | done))
                       | tick_reload;

    // Counter, prescaler, shadow and flag state; reloads take priority over normal ticks.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_start   <= '0;
            r_end     <= '0;
            r_presc   <= '0;
            r_mode    <= MODE_UP;
            r_oneshot <= 1'b0;
            cnt       <= '0;
            dir       <= 1'b0;
            presc_cnt <= '0;
            pending   <= 1'b0;
            done      <= 1'b0;
            evt       <= 1'b0;
            end_pulse <= 1'b0;
        end else begin
            evt       <= 1'b0;
            end_pulse <= 1'b0;
            if (reload) begin
                r_start   <= cfg_start_i;
                r_end     <= cfg_end_i;
                r_presc   <= cfg_presc_i;
                r_mode    <= mode_e'(cfg_mode_i);
                r_oneshot <= cfg_oneshot_i;
                cnt       <= load_cnt;
                dir       <= load_dir;
                presc_cnt <= '0;
                pending   <= 1'b0;
                done      <= 1'b0;
                // A reload replacing a period-end wrap still reports the period end.
                end_pulse <= tick_reload & ~ctrl_rst_i;
            end else begin
                if (qev) begin
                    presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
                end
                if (tick) begin
                    evt       <= 1'b1;
                    end_pulse <= period_end;
                    if (period_end && r_oneshot) begin
                        done <= 1'b1;
                    end else begin
                        cnt <= adv_cnt;
                        dir <= adv_dir;
                    end
                end
                if (ctrl_update_i) begin
                    pending <= 1'b1;
                end
            end
        end
    end

    assign counter_o      = cnt;
    assign counter_dir_o  = dir;
    assign counter_evt_o  = evt;
    assign counter_end_o  = end_pulse;
    assign counter_done_o = done;

endmodule
